breakout_game_ctrl: RTL

Game-flow sequencer for the breakout datapath. It owns the round state machine (attract, serve, play, miss, clear, game over) and the lives, score, level and blocks-remaining counters. It tells the ball/paddle/block logic when to hold start positions, when to move, and when to re-arm the block wall. It runs in the pixel clock domain and advances its frame-based timers on the once-per-frame `frame` strobe from the VGA timing logic.

---
 rtl/breakout_game_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/breakout_game_ctrl.sv
// Round sequencer for the breakout game: attract/serve/play/miss/clear/over flow
// plus lives, score, level and blocks-remaining bookkeeping, paced by the frame strobe.
module breakout_game_ctrl #(
  parameter int LIVES_INIT    = 3,
  parameter int NUM_BLOCKS    = 5,
  parameter int PTS_PER_BLOCK = 10,
  parameter int SERVE_FRAMES  = 60,
  parameter int MISS_FRAMES   = 90,
  parameter int CLEAR_FRAMES  = 120
) (
  input  logic        pix_clk,
  input  logic        reset_n,
  input  logic        frame,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        ball_lost,
  input  logic        block_hit,
  output logic [2:0]  state,
  output logic        serve,
  output logic        play_en,
  output logic        blocks_reload,
  output logic [3:0]  lives,
  output logic [15:0] score,
  output logic [3:0]  level,
  output logic [3:0]  blocks_left
);

  typedef enum logic [2:0] {
    S_ATTRACT = 3'd0,
    S_SERVE   = 3'd1,
    S_PLAY    = 3'd2,
    S_MISS    = 3'd3,
    S_CLEAR   = 3'd4,
    S_OVER    = 3'd5
  } state_e;

  localparam logic [7:0] OVER_LOCKOUT = 8'd30;

  state_e      state_q, state_d;
  logic [7:0]  tmr_q, tmr_d;
  logic        btn_prev_q, btn_prev_d;
  logic [3:0]  lives_q, lives_d;
  logic [15:0] score_q, score_d;
  logic [3:0]  level_q, level_d;
  logic [3:0]  blocks_left_q, blocks_left_d;
  logic        reload_q, reload_d;
  logic        serve_q, serve_d;
  logic        play_en_q, play_en_d;

  logic        btn_any, press, timed_state;
  logic [16:0] score_sum;

  assign btn_any     = btn_left | btn_right;
  assign press       = frame & btn_any & ~btn_prev_q;
  assign timed_state = (state_q == S_SERVE) || (state_q == S_MISS) ||
                       (state_q == S_CLEAR) || (state_q == S_OVER);
  assign score_sum   = {1'b0, score_q} + 17'(PTS_PER_BLOCK);

  // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d       = state_q;
    tmr_d         = tmr_q;
    btn_prev_d    = frame ? btn_any : btn_prev_q;
    lives_d       = lives_q;
    score_d       = score_q;
    level_d       = level_q;
    blocks_left_d = blocks_left_q;
    reload_d      = 1'b0;

    case (state_q)
      S_ATTRACT: if (press) begin
        lives_d       = 4'(LIVES_INIT);
        score_d       = '0;
        level_d       = '0;
        blocks_left_d = 4'(NUM_BLOCKS);
        reload_d      = 1'b1;
        state_d       = S_SERVE;
      end
      S_SERVE: if (frame && tmr_q == 8'(SERVE_FRAMES - 1)) state_d = S_PLAY;
      S_PLAY: begin
        // A hit that empties the wall wins over a simultaneous miss.
        if (block_hit && blocks_left_q != 4'd0) begin
          score_d       = score_sum[16] ? 16'hFFFF : score_sum[15:0];
          blocks_left_d = blocks_left_q - 4'd1;
          if (blocks_left_q == 4'd1) state_d = S_CLEAR;
        end
        if (ball_lost && state_d == S_PLAY) begin
          lives_d = (lives_q != 4'd0) ? lives_q - 4'd1 : 4'd0;
          state_d = S_MISS;
        end
      end
      S_MISS: if (frame && tmr_q == 8'(MISS_FRAMES - 1))
        state_d = (lives_q == 4'd0) ? S_OVER : S_SERVE;
      S_CLEAR: if (frame && tmr_q == 8'(CLEAR_FRAMES - 1)) begin
        level_d       = (level_q == 4'd15) ? 4'd15 : level_q + 4'd1;
        blocks_left_d = 4'(NUM_BLOCKS);
        reload_d      = 1'b1;
        state_d       = S_SERVE;
      end
      S_OVER: if (press && tmr_q >= OVER_LOCKOUT) state_d = S_ATTRACT;
      default: state_d = S_ATTRACT;
    endcase

    if (state_d != state_q)      tmr_d = '0;
    else if (frame && timed_state) tmr_d = tmr_q + 8'd1;

    serve_d   = (state_d == S_ATTRACT) || (state_d == S_SERVE);
    play_en_d = (state_d == S_PLAY);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge pix_clk) begin
    if (!reset_n) begin
      state_q       <= S_ATTRACT;
      tmr_q         <= '0;
      btn_prev_q    <= 1'b1;
      lives_q       <= 4'(LIVES_INIT);
      score_q       <= '0;
      level_q       <= '0;
      blocks_left_q <= 4'(NUM_BLOCKS);
      reload_q      <= 1'b0;
      serve_q       <= 1'b1;
      play_en_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      tmr_q         <= tmr_d;
      btn_prev_q    <= btn_prev_d;
      lives_q       <= lives_d;
      score_q       <= score_d;
      level_q       <= level_d;
      blocks_left_q <= blocks_left_d;
      reload_q      <= reload_d;
      serve_q       <= serve_d;
      play_en_q     <= play_en_d;
    end
  end

  assign state         = state_q;
  assign serve         = serve_q;
  assign play_en       = play_en_q;
  assign blocks_reload = reload_q;
  assign lives         = lives_q;
  assign score         = score_q;
  assign level         = level_q;
  assign blocks_left   = blocks_left_q;

endmodule
